fifo_stack: RTL and testbench

- Parametrised successor to the team's 4x4 FIFO: one storage array that runs as a FIFO queue or a LIFO stack, selected at run time.
- Separate read/write strobes replace the 2-bit opcode, so read and write can happen in the same cycle.
- Adds occupancy count, almost-full/almost-empty flags, registered read-valid and a synchronous reset port.
- Sits between producer/consumer datapath stages in lab designs; standalone, no external memory.

---
 rtl/fifo_stack_pkg.sv | 14 +
 rtl/fifo_stack_mem.sv | 26 ++
 rtl/fifo_stack.sv | 110 +++++++++++
 tb/tb_fifo_stack.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/fifo_stack_pkg.sv
// Shared definitions for the FIFO/stack buffer: operating modes and width helper.
package fifo_stack_pkg;

    typedef enum logic {
        MODE_FIFO  = 1'b0,
        MODE_STACK = 1'b1
    } mode_e;

    // Occupancy counter needs one extra bit to represent a completely full array.
    function automatic int count_width(input int index_width);
        return index_width + 1;
    endfunction

endpackage

// File: rtl/fifo_stack_mem.sv
// Storage array: one synchronous write port, one combinational read port.
module fifo_stack_mem
    import fifo_stack_pkg::*;
#(
    parameter int data_width   = 8,
    parameter int num_elements = 8,
    parameter int index_width  = 3
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [index_width-1:0] waddr,
    input  logic [data_width-1:0]  wdata,
    input  logic [index_width-1:0] raddr,
    output logic [data_width-1:0]  rdata
);

    logic [data_width-1:0] mem [num_elements];

    // Contents survive reset; only the controller's pointers are cleared.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_stack.sv
// Single storage array operated as a FIFO queue or LIFO stack, chosen while empty.
module fifo_stack
    import fifo_stack_pkg::*;
#(
    parameter int data_width       = 8,
    parameter int num_elements     = 8,
    parameter int index_width      = 3,
    parameter int almost_full_lvl  = 6,
    parameter int almost_empty_lvl = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mode,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [data_width-1:0]  data_in,
    output logic [data_width-1:0]  data_out,
    output logic                   valid_out,
    output logic [index_width:0]   count,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic                   overflow,
    output logic                   underflow,
    output logic                   mode_err
);

    localparam int CW = count_width(index_width);
    localparam logic [CW-1:0] FULL_CNT = CW'(num_elements);
    localparam logic [CW-1:0] AF_CNT   = CW'(almost_full_lvl);
    localparam logic [CW-1:0] AE_CNT   = CW'(almost_empty_lvl);

    mode_e                  active_mode, eff_mode;
    logic [index_width-1:0] head, tail;
    logic [index_width-1:0] waddr, raddr;
    logic [data_width-1:0]  rdata;
    logic [CW-1:0]          count_m1;
    logic                   is_empty, is_full, do_rd, do_wr;

    assign is_empty = (count == '0);
    assign is_full  = (count == FULL_CNT);
    assign count_m1 = count - CW'(1);

    // An empty buffer adopts the requested mode immediately; otherwise the latched mode rules.
    assign eff_mode = is_empty ? mode_e'(mode) : active_mode;

    // A read frees a slot, so a write into a full buffer is accepted alongside a read.
    assign do_rd = rd_en && !is_empty;
    assign do_wr = wr_en && (!is_full || do_rd);

    // Address selection: pointers for FIFO, occupancy for stack (swap overwrites the top).
    always_comb begin
        waddr = head;
        raddr = tail;
        if (eff_mode == MODE_STACK) begin
            raddr = count_m1[index_width-1:0];
            waddr = do_rd ? count_m1[index_width-1:0] : count[index_width-1:0];
        end
    end

    fifo_stack_mem #(
        .data_width  (data_width),
        .num_elements(num_elements),
        .index_width (index_width)
    ) u_mem (
        .clk  (clk),
        .we   (do_wr && !rst),
        .waddr(waddr),
        .wdata(data_in),
        .raddr(raddr),
        .rdata(rdata)
    );

    // Control state, read register and one-cycle status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            head        <= '0;
            tail        <= '0;
            active_mode <= MODE_FIFO;
            data_out    <= '0;
            valid_out   <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            mode_err    <= 1'b0;
        end else begin
            active_mode <= eff_mode;
            count       <= count + CW'(do_wr) - CW'(do_rd);
            if (eff_mode == MODE_STACK) begin
                head <= '0;
                tail <= '0;
            end else begin
                if (do_wr) head <= head + 1'b1;
                if (do_rd) tail <= tail + 1'b1;
            end
            if (do_rd) data_out <= rdata;
            valid_out <= do_rd;
            overflow  <= wr_en && is_full && !do_rd;
            underflow <= rd_en && is_empty;
            mode_err  <= !is_empty && (mode != active_mode);
        end
    end

    assign full         = is_full;
    assign empty        = is_empty;
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);

endmodule

// File: tb/tb_fifo_stack.sv
// Directed bench: expected read data goes into a scoreboard queue, a monitor checks valid_out beats.
module tb_fifo_stack;

    logic       clk = 1'b0;
    logic       rst, mode, wr_en, rd_en;
    logic [7:0] data_in, data_out;
    logic       valid_out, full, empty, almost_full, almost_empty;
    logic       overflow, underflow, mode_err;
    logic [3:0] count;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] sb[$];

    fifo_stack dut (
        .clk(clk), .rst(rst), .mode(mode), .wr_en(wr_en), .rd_en(rd_en),
        .data_in(data_in), .data_out(data_out), .valid_out(valid_out), .count(count),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow), .mode_err(mode_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock of stimulus; a read carrying an expectation queues it for the monitor.
    task automatic op(input logic w, input logic r, input logic [7:0] d,
                      input logic exp_rd, input logic [7:0] exp_d);
        wr_en = w; rd_en = r; data_in = d;
        if (exp_rd) sb.push_back(exp_d);
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic wr(input logic [7:0] d); op(1'b1, 1'b0, d, 1'b0, 8'h00); endtask
    task automatic rd(input logic [7:0] e); op(1'b0, 1'b1, 8'h00, 1'b1, e); endtask
    task automatic idle();                  op(1'b0, 1'b0, 8'h00, 1'b0, 8'h00); endtask

    // Monitor: every valid_out beat must match the oldest queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (valid_out === 1'b1) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_valid: got data %0h with nothing expected", data_out);
                end else begin
                    check("read_data", {24'h0, data_out}, {24'h0, sb.pop_front()});
                end
            end
        end
    end

    initial begin
        rst = 1'b1; mode = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", {28'h0, count}, 0);
        check("rst_flags", {26'h0, empty, almost_empty, full, almost_full, valid_out, overflow},
              32'b110000);
        check("rst_pulses", {30'h0, underflow, mode_err}, 0);
        check("rst_data", {24'h0, data_out}, 0);
        rst = 1'b0;

        // FIFO order
        wr(8'h11); wr(8'h22); wr(8'h33);
        check("fifo_count3", {28'h0, count}, 3);
        rd(8'h11); rd(8'h22); rd(8'h33);
        check("fifo_drained", {27'h0, empty, count}, 32'h10);

        // Stack order and pop underflow
        mode = 1'b1;
        wr(8'hA1); wr(8'hB2); wr(8'hC3);
        rd(8'hC3); rd(8'hB2); rd(8'hA1);
        op(1'b0, 1'b1, 8'h00, 1'b0, 8'h00);
        check("stk_underflow", {30'h0, underflow, valid_out}, 32'b10);
        check("stk_hold", {24'h0, data_out}, 32'hA1);
        idle();
        check("udf_clear", {31'h0, underflow}, 0);

        // FIFO fill, flags, overflow, swap at full, drain across wrap
        mode = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            wr(8'(i));
            if (i == 2) check("ae_at2", {31'h0, almost_empty}, 1);
            if (i == 3) check("ae_at3", {31'h0, almost_empty}, 0);
            if (i == 5) check("af_at5", {31'h0, almost_full}, 0);
            if (i == 6) check("af_at6", {31'h0, almost_full}, 1);
        end
        check("full8", {27'h0, full, count}, 32'h18);
        wr(8'hEE);
        check("overflow", {27'h0, overflow, count}, 32'h18);
        op(1'b1, 1'b1, 8'h09, 1'b1, 8'h01);
        check("swap_full", {26'h0, overflow, full, count}, 32'h18);
        for (int i = 2; i <= 9; i++) rd(8'(i));
        check("drain_empty", {27'h0, empty, count}, 32'h10);

        // Stack swap at count 3
        mode = 1'b1;
        wr(8'h11); wr(8'h22); wr(8'h33);
        op(1'b1, 1'b1, 8'h44, 1'b1, 8'h33);
        check("stk_swap_cnt", {28'h0, count}, 3);
        rd(8'h44); rd(8'h22); rd(8'h11);

        // Mode change refused while non-empty
        mode = 1'b0;
        wr(8'h55); wr(8'h66);
        mode = 1'b1;
        idle();
        check("mode_err", {31'h0, mode_err}, 1);
        rd(8'h55); rd(8'h66);
        idle();
        check("mode_err_clr", {31'h0, mode_err}, 0);
        wr(8'h77); wr(8'h88);
        rd(8'h88); rd(8'h77);

        // Reset mid-stream beats a write
        mode = 1'b0;
        for (int i = 0; i < 5; i++) wr(8'hC0 + 8'(i));
        check("pre_rst_cnt", {28'h0, count}, 5);
        rst = 1'b1;
        op(1'b1, 1'b0, 8'hEE, 1'b0, 8'h00);
        rst = 1'b0;
        check("midrst", {22'h0, data_out, empty, valid_out}, 32'b10);
        check("midrst_cnt", {28'h0, count}, 0);
        op(1'b0, 1'b1, 8'h00, 1'b0, 8'h00);
        check("post_rst_udf", {30'h0, underflow, valid_out}, 32'b10);
        idle();

        check("sb_pending", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
